// File: rtl/fifo_pkt_wr_ctrl.sv
// Write-side controller for a packet FIFO. Writes land speculatively at fill_ptr and
// become visible to the reader only when committed into wr_ptr.
module fifo_pkt_wr_ctrl #(
  parameter int MEM_WIDTH    = 16,
  parameter int W_DATA_WIDTH = 32,
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_THRESH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_request,
  input  logic                  wr_commit,
  input  logic                  wr_abort,
  input  logic                  clr_ovf,
  input  logic [ADDR_WIDTH:0]   rd_ptr,
  output logic [ADDR_WIDTH:0]   wr_ptr,
  output logic [ADDR_WIDTH:0]   fill_ptr,
  output logic                  wr_en,
  output logic                  full_flag,
  output logic                  almost_full,
  output logic                  overflow,
  output logic [ADDR_WIDTH:0]   free_words,
  output logic [ADDR_WIDTH:0]   pending_words
);

  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int RATIO = W_DATA_WIDTH / MEM_WIDTH;

  localparam logic [PW-1:0] DEPTH_W = PW'(DEPTH);
  localparam logic [PW-1:0] RATIO_W = PW'(RATIO);
  localparam logic [PW-1:0] AFULL_W = PW'(AFULL_THRESH);

  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] fill_q, fill_d;
  logic          ovf_q, ovf_d;
  logic [PW-1:0] used_words;
  logic          reject;

  // Pointer differences wrap modulo 2^(ADDR_WIDTH+1); the extra bit disambiguates full from empty.
  always_comb begin
    used_words    = fill_q - rd_ptr;
    free_words    = DEPTH_W - used_words;
    pending_words = fill_q - wr_q;
    full_flag     = (free_words < RATIO_W);
    almost_full   = (free_words <= AFULL_W);
    wr_en         = wr_request & ~full_flag & ~wr_abort;
    reject        = wr_request & full_flag & ~wr_abort;
  end

  // Abort rolls the speculative pointer back; a commit publishes the post-write fill pointer.
  always_comb begin
    fill_d = fill_q;
    wr_d   = wr_q;
    if (wr_abort) begin
      fill_d = wr_q;
    end else begin
      if (wr_en) begin
        fill_d = fill_q + RATIO_W;
      end
      if (wr_commit) begin
        wr_d = fill_d;
      end
    end
  end

  // Setting wins over clearing so a rejection in the clear cycle is never lost.
  always_comb begin
    ovf_d = reject | (ovf_q & ~clr_ovf);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q   <= '0;
      fill_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      wr_q   <= wr_d;
      fill_q <= fill_d;
      ovf_q  <= ovf_d;
    end
  end

  assign wr_ptr   = wr_q;
  assign fill_ptr = fill_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_fifo_pkt_wr_ctrl.sv
// Self-checking bench for fifo_pkt_wr_ctrl (DEPTH 16, RATIO 2): directed scenarios
// followed by a randomized run against a pointer-arithmetic reference model.
module tb_fifo_pkt_wr_ctrl;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int RATIO = 2;
  localparam int MOD   = 32;

  logic          clk = 1'b0;
  logic          reset, wr_request, wr_commit, wr_abort, clr_ovf;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   wr_ptr, fill_ptr, free_words, pending_words;
  logic          wr_en, full_flag, almost_full, overflow;

  int checks = 0;
  int failures = 0;

  fifo_pkt_wr_ctrl #(
    .MEM_WIDTH(16), .W_DATA_WIDTH(32), .ADDR_WIDTH(AW), .AFULL_THRESH(4)
  ) dut (
    .clk(clk), .reset(reset), .wr_request(wr_request), .wr_commit(wr_commit),
    .wr_abort(wr_abort), .clr_ovf(clr_ovf), .rd_ptr(rd_ptr), .wr_ptr(wr_ptr),
    .fill_ptr(fill_ptr), .wr_en(wr_en), .full_flag(full_flag), .almost_full(almost_full),
    .overflow(overflow), .free_words(free_words), .pending_words(pending_words)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, let it pass the rising edge, return just after it.
  task automatic cyc(input logic rst, input logic req, input logic cm, input logic ab, input logic clr);
    reset = rst; wr_request = req; wr_commit = cm; wr_abort = ab; clr_ovf = clr;
    @(posedge clk); #1;
    reset = 1'b0; wr_request = 1'b0; wr_commit = 1'b0; wr_abort = 1'b0; clr_ovf = 1'b0;
  endtask

  task automatic test_reset;
    rd_ptr = '0;
    cyc(1, 1, 1, 0, 0);
    reset = 1'b1; wr_request = 1'b1; #1;
    checks++; if (full_flag !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full_flag); end
    checks++; if (free_words !== 5'd16) begin failures++; $display("FAIL reset_free got=%0d exp=16", free_words); end
    checks++; if (pending_words !== 5'd0) begin failures++; $display("FAIL reset_pending got=%0d exp=0", pending_words); end
    cyc(1, 1, 0, 0, 0);
    checks++; if (fill_ptr !== 5'd0 || wr_ptr !== 5'd0 || overflow !== 1'b0) begin
      failures++; $display("FAIL reset_state fill=%0d wr=%0d ovf=%b exp=0/0/0", fill_ptr, wr_ptr, overflow);
    end
    $display("test_reset done");
  endtask

  task automatic test_commit;
    rd_ptr = '0;
    cyc(1, 0, 0, 0, 0);
    wr_request = 1'b1; #1;
    checks++; if (wr_en !== 1'b1) begin failures++; $display("FAIL commit_wr_en got=%b exp=1", wr_en); end
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0);
    checks++; if (pending_words !== 5'd6 || wr_ptr !== 5'd0) begin
      failures++; $display("FAIL commit_pending got=%0d wr=%0d exp=6/0", pending_words, wr_ptr);
    end
    cyc(0, 0, 1, 0, 0);
    checks++; if (fill_ptr !== 5'd6 || wr_ptr !== 5'd6 || pending_words !== 5'd0 || free_words !== 5'd10) begin
      failures++; $display("FAIL commit_3beats fill=%0d wr=%0d pend=%0d free=%0d exp=6/6/0/10",
                           fill_ptr, wr_ptr, pending_words, free_words);
    end
    cyc(0, 0, 1, 0, 0);
    checks++; if (fill_ptr !== 5'd6 || wr_ptr !== 5'd6) begin
      failures++; $display("FAIL commit_empty fill=%0d wr=%0d exp=6/6", fill_ptr, wr_ptr);
    end
    $display("test_commit done");
  endtask

  task automatic test_abort;
    rd_ptr = '0;
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    wr_request = 1'b1; wr_abort = 1'b1; wr_commit = 1'b1; #1;
    checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL abort_wr_en got=%b exp=0", wr_en); end
    cyc(0, 1, 1, 1, 0);
    checks++; if (fill_ptr !== 5'd0 || wr_ptr !== 5'd0 || overflow !== 1'b0) begin
      failures++; $display("FAIL abort_ptrs fill=%0d wr=%0d ovf=%b exp=0/0/0", fill_ptr, wr_ptr, overflow);
    end
    $display("test_abort done");
  endtask

  task automatic test_full_overflow;
    rd_ptr = '0;
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0, 0);
    checks++; if (full_flag !== 1'b1 || free_words !== 5'd0) begin
      failures++; $display("FAIL full_flag full=%b free=%0d exp=1/0", full_flag, free_words);
    end
    wr_request = 1'b1; #1;
    checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL full_wr_en got=%b exp=0", wr_en); end
    cyc(0, 1, 0, 0, 0);
    checks++; if (overflow !== 1'b1 || fill_ptr !== 5'd16) begin
      failures++; $display("FAIL overflow_set ovf=%b fill=%0d exp=1/16", overflow, fill_ptr);
    end
    cyc(0, 1, 0, 0, 1);
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set_wins got=%b exp=1", overflow); end
    cyc(0, 0, 0, 0, 1);
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
    $display("test_full_overflow done");
  endtask

  task automatic test_wrap;
    rd_ptr = 5'd14;
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) cyc(0, 1, 1, 0, 0);
    checks++; if (fill_ptr !== 5'd30 || wr_ptr !== 5'd30) begin
      failures++; $display("FAIL wrap_setup fill=%0d wr=%0d exp=30/30", fill_ptr, wr_ptr);
    end
    rd_ptr = 5'd16;
    cyc(0, 1, 1, 0, 0);
    checks++; if (fill_ptr !== 5'd0 || wr_ptr !== 5'd0 || free_words !== 5'd0) begin
      failures++; $display("FAIL wrap_ptrs fill=%0d wr=%0d free=%0d exp=0/0/0", fill_ptr, wr_ptr, free_words);
    end
    rd_ptr = 5'd0; #1;
    checks++; if (free_words !== 5'd16 || full_flag !== 1'b0) begin
      failures++; $display("FAIL wrap_drained free=%0d full=%b exp=16/0", free_words, full_flag);
    end
    $display("test_wrap done");
  endtask

  task automatic test_almost_full_reset;
    rd_ptr = '0;
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0);
    checks++; if (almost_full !== 1'b0 || free_words !== 5'd6) begin
      failures++; $display("FAIL afull_6 af=%b free=%0d exp=0/6", almost_full, free_words);
    end
    cyc(0, 1, 0, 0, 0);
    checks++; if (almost_full !== 1'b1 || free_words !== 5'd4) begin
      failures++; $display("FAIL afull_4 af=%b free=%0d exp=1/4", almost_full, free_words);
    end
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0);
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL afull_ovf got=%b exp=1", overflow); end
    cyc(1, 1, 1, 0, 0);
    checks++; if (fill_ptr !== 5'd0 || wr_ptr !== 5'd0 || overflow !== 1'b0 || pending_words !== 5'd0) begin
      failures++; $display("FAIL midpkt_reset fill=%0d wr=%0d ovf=%b pend=%0d exp=0/0/0/0",
                           fill_ptr, wr_ptr, overflow, pending_words);
    end
    $display("test_almost_full_reset done");
  endtask

  // Reference model: plain modular pointer arithmetic on integers.
  task automatic test_random;
    int m_fill, m_wr, used, free, pend;
    bit m_ovf, e_full, e_af, e_en, req, cm, ab, clr, rst;
    cyc(1, 0, 0, 0, 0);
    m_fill = 0; m_wr = 0; m_ovf = 0;
    for (int n = 0; n < 400; n++) begin
      rd_ptr = 5'((m_fill - int'($urandom_range(0, DEPTH)) + MOD) % MOD);
      req = ($urandom_range(0, 3) != 0);
      cm  = ($urandom_range(0, 4) == 0);
      ab  = ($urandom_range(0, 12) == 0);
      clr = ($urandom_range(0, 6) == 0);
      rst = ($urandom_range(0, 60) == 0);
      used   = (m_fill - int'(rd_ptr) + MOD) % MOD;
      free   = DEPTH - used;
      pend   = (m_fill - m_wr + MOD) % MOD;
      e_full = (free < RATIO);
      e_af   = (free <= 4);
      e_en   = req && !e_full && !ab;
      reset = rst; wr_request = req; wr_commit = cm; wr_abort = ab; clr_ovf = clr; #1;
      checks++;
      if (wr_en !== e_en || full_flag !== e_full || almost_full !== e_af ||
          free_words !== 5'(free) || pending_words !== 5'(pend)) begin
        failures++;
        $display("FAIL rand_comb n=%0d en=%b full=%b af=%b free=%0d pend=%0d exp=%b/%b/%b/%0d/%0d",
                 n, wr_en, full_flag, almost_full, free_words, pending_words, e_en, e_full, e_af, free, pend);
      end
      if (rst) begin
        m_fill = 0; m_wr = 0; m_ovf = 0;
      end else begin
        m_ovf = (req && e_full && !ab) || (m_ovf && !clr);
        if (ab) m_fill = m_wr;
        else begin
          if (e_en) m_fill = (m_fill + RATIO) % MOD;
          if (cm) m_wr = m_fill;
        end
      end
      @(posedge clk); #1;
      checks++;
      if (fill_ptr !== 5'(m_fill) || wr_ptr !== 5'(m_wr) || overflow !== m_ovf) begin
        failures++;
        $display("FAIL rand_state n=%0d fill=%0d wr=%0d ovf=%b exp=%0d/%0d/%b",
                 n, fill_ptr, wr_ptr, overflow, m_fill, m_wr, m_ovf);
      end
    end
    reset = 1'b0; wr_request = 1'b0; wr_commit = 1'b0; wr_abort = 1'b0; clr_ovf = 1'b0;
    $display("test_random done");
  endtask

  initial begin
    reset = 1'b1; wr_request = 1'b0; wr_commit = 1'b0; wr_abort = 1'b0; clr_ovf = 1'b0;
    rd_ptr = '0;
    @(posedge clk); #1;
    test_reset;
    test_commit;
    test_abort;
    test_full_overflow;
    test_wrap;
    test_almost_full_reset;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
